// File: rtl/ls_pkg.sv
// ls_pkg
//   Shared definitions for the load/store unit: op encodings, FSM state
//   encoding and small decode helpers used by both ls_unit and ls_align.
//   No ports (package).

package ls_pkg;

  typedef enum logic [2:0] {
    LS_LB  = 3'b000,
    LS_LH  = 3'b001,
    LS_LW  = 3'b010,
    LS_LBU = 3'b011,
    LS_LHU = 3'b100,
    LS_SB  = 3'b101,
    LS_SH  = 3'b110,
    LS_SW  = 3'b111
  } ls_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    WAIT,
    RESP
  } ls_state_e;

  // True for the three store encodings; everything else is a load.
  function automatic logic is_store(input logic [2:0] op);
    return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
  endfunction

  // Access size in bytes (1, 2 or 4).
  function automatic logic [2:0] op_size(input logic [2:0] op);
    case (op)
      LS_LB, LS_LBU, LS_SB: op_size = 3'd1;
      LS_LH, LS_LHU, LS_SH: op_size = 3'd2;
      default:              op_size = 3'd4;
    endcase
  endfunction

  // An access crosses a word boundary when its last byte lands in the next word.
  function automatic logic is_crossing(input logic [2:0] op, input logic [1:0] off);
    case (op_size(op))
      3'd4:    is_crossing = (off != 2'd0);
      3'd2:    is_crossing = (off == 2'd3);
      default: is_crossing = 1'b0;
    endcase
  endfunction

  // Natural-alignment violation, independent of whether it crosses a word.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op_size(op))
      3'd4:    is_misaligned = (off != 2'd0);
      3'd2:    is_misaligned = off[0];
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ls_align.sv
// ls_align
//   Purely combinational lane steering for the load/store unit (big-endian,
//   byte offset 0 is the MSB lane).
//   Ports:
//     op_i      - access op (ls_op_e encoding)
//     off_i     - byte offset within the beat-0 word
//     beat_i    - 0 = first word, 1 = following word of a crossing access
//     wdata_i   - right-justified store data
//     word0_i   - beat-0 read word, word1_i - beat-1 read word
//     mask_o    - byte lane mask for the selected beat (bit3 = lane 0)
//     lane_o    - lane-aligned store data for the selected beat
//     load_o    - assembled and sign/zero-extended load result

module ls_align
  import ls_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic        beat_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word0_i,
  input  logic [31:0] word1_i,
  output logic [3:0]  mask_o,
  output logic [31:0] lane_o,
  output logic [31:0] load_o
);

  logic [4:0]  shiftBits;
  logic [31:0] justified;
  logic [3:0]  sizeMask;
  logic [63:0] spread;
  logic [7:0]  maskSpread;
  logic [31:0] loadBytes;

  // Store path: left-justify the store bytes, then slide them across a
  // two-word window so the MSB byte lands in lane off_i. The upper word of
  // the window is beat 0, the lower word is beat 1.
  always_comb begin
    shiftBits = {off_i, 3'b000};
    case (op_size(op_i))
      3'd1: begin
        justified = {wdata_i[7:0], 24'h0};
        sizeMask  = 4'b1000;
      end
      3'd2: begin
        justified = {wdata_i[15:0], 16'h0};
        sizeMask  = 4'b1100;
      end
      default: begin
        justified = wdata_i;
        sizeMask  = 4'b1111;
      end
    endcase
    spread     = {justified, 32'h0} >> shiftBits;
    maskSpread = {sizeMask, 4'b0000} >> off_i;
    mask_o     = beat_i ? maskSpread[3:0] : maskSpread[7:4];
    lane_o     = beat_i ? spread[31:0] : spread[63:32];
  end

  // Load path: shift the two-word window left by the offset so the first
  // requested byte sits in the MSB, then pick and extend the leading bytes.
  // Bytes beyond the access size (garbage from word1 on single-beat loads)
  // are never selected.
  always_comb begin
    loadBytes = 32'(({word0_i, word1_i} << shiftBits) >> 32);
    case (op_i)
      LS_LB:   load_o = {{24{loadBytes[31]}}, loadBytes[31:24]};
      LS_LBU:  load_o = {24'h0, loadBytes[31:24]};
      LS_LH:   load_o = {{16{loadBytes[31]}}, loadBytes[31:16]};
      LS_LHU:  load_o = {16'h0, loadBytes[31:16]};
      LS_LW:   load_o = loadBytes;
      default: load_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/ls_unit.sv
// ls_unit
//   Handshaked load/store unit between execute and the imem/dmem block RAMs.
//   Accepts one request at a time, issues one or two memory beats, waits the
//   memory read latency for loads and returns a one-cycle response.
//   Ports:
//     clk, rst                 - clock, asynchronous active-high reset
//     req_valid/req_ready      - request handshake
//     req_op/addr/wdata        - op, byte address, right-justified store data
//     mem_en, mem_adr          - beat strobe and word address
//     we_i, we_d               - imem/dmem byte enables (bit3 = lane 0)
//     mem_wdata                - lane-aligned store data
//     mem_rdata_i/mem_rdata_d  - imem/dmem read data
//     resp_valid/data/misalign - completion pulse, load result, reject flag

module ls_unit
  import ls_pkg::*;
#(
  parameter int ADDR_W          = 12,
  parameter int MEM_LATENCY     = 1,
  parameter int ALLOW_UNALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [3:0]        we_i,
  output logic [3:0]        we_d,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata_i,
  input  logic [31:0]       mem_rdata_d,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              misalign
);

  localparam logic [1:0] WAIT_INIT = 2'(MEM_LATENCY - 1);

  ls_state_e         state_q;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] wordA_q;
  logic              storeI_q, storeD_q, readD_q, readI_q, beat_q;
  logic [31:0]       wdata_q, word0_q;
  logic [1:0]        cnt_q;
  logic              reqReady_q, memEn_q, respValid_q, misalign_q;
  logic [ADDR_W-1:0] memAdr_q;
  logic [3:0]        weI_q, weD_q;
  logic [31:0]       memWdata_q, respData_q;

  logic              idle, nextBeat, crossing, reqMisaligned;
  logic [2:0]        srcOp;
  logic [1:0]        srcOff;
  logic [31:0]       srcWdata;
  logic [ADDR_W-1:0] srcWordA, beatAdr_d;
  logic              srcStoreI, srcStoreD;
  logic [3:0]        weI_d, weD_d, beatMask;
  logic [31:0]       wdata_d, beatData, readWord, loadW0, loadResult;
  logic              unusedBits;

  assign unusedBits = ^req_addr;

  // The next beat is described either by the live request (when accepting
  // in IDLE, always beat 0) or by the latched request (only ever beat 1).
  // This lets the beat outputs be registered on the same edge that decides
  // to issue them.
  always_comb begin
    idle          = (state_q == IDLE);
    nextBeat      = !idle;
    srcOp         = idle ? req_op : op_q;
    srcOff        = idle ? req_addr[1:0] : off_q;
    srcWdata      = idle ? req_wdata : wdata_q;
    srcWordA      = idle ? req_addr[ADDR_W+1:2] : wordA_q;
    srcStoreI     = idle ? (!req_addr[31] && req_addr[29]) : storeI_q;
    srcStoreD     = idle ? (!req_addr[31] && req_addr[28]) : storeD_q;
    beatAdr_d     = nextBeat ? srcWordA + ADDR_W'(1) : srcWordA;
    weI_d         = (is_store(srcOp) && srcStoreI) ? beatMask : 4'b0000;
    weD_d         = (is_store(srcOp) && srcStoreD) ? beatMask : 4'b0000;
    wdata_d       = is_store(srcOp) ? beatData : 32'h0;
    crossing      = is_crossing(op_q, off_q);
    reqMisaligned = is_misaligned(req_op, req_addr[1:0]);
  end

  // Load source follows the beat-0 region: dmem wins over imem, and an
  // address in neither region reads as zero.
  always_comb begin
    if (readD_q)      readWord = mem_rdata_d;
    else if (readI_q) readWord = mem_rdata_i;
    else              readWord = 32'h0;
    loadW0 = beat_q ? word0_q : readWord;
  end

  ls_align u_align (
    .op_i    (srcOp),
    .off_i   (srcOff),
    .beat_i  (nextBeat),
    .wdata_i (srcWdata),
    .word0_i (loadW0),
    .word1_i (readWord),
    .mask_o  (beatMask),
    .lane_o  (beatData),
    .load_o  (loadResult)
  );

  // Main FSM with registered outputs. Strobes (mem_en, enables, resp_valid)
  // default low every cycle and are raised only on the edge that enters the
  // state they belong to, so each is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 3'b000;
      off_q       <= 2'b00;
      wordA_q     <= '0;
      storeI_q    <= 1'b0;
      storeD_q    <= 1'b0;
      readD_q     <= 1'b0;
      readI_q     <= 1'b0;
      beat_q      <= 1'b0;
      wdata_q     <= 32'h0;
      word0_q     <= 32'h0;
      cnt_q       <= 2'd0;
      reqReady_q  <= 1'b1;
      memEn_q     <= 1'b0;
      memAdr_q    <= '0;
      weI_q       <= 4'b0000;
      weD_q       <= 4'b0000;
      memWdata_q  <= 32'h0;
      respValid_q <= 1'b0;
      respData_q  <= 32'h0;
      misalign_q  <= 1'b0;
    end else begin
      memEn_q     <= 1'b0;
      weI_q       <= 4'b0000;
      weD_q       <= 4'b0000;
      respValid_q <= 1'b0;
      respData_q  <= 32'h0;
      misalign_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            off_q      <= req_addr[1:0];
            wordA_q    <= srcWordA;
            storeI_q   <= srcStoreI;
            storeD_q   <= srcStoreD;
            readD_q    <= req_addr[28];
            readI_q    <= req_addr[29];
            wdata_q    <= req_wdata;
            beat_q     <= 1'b0;
            reqReady_q <= 1'b0;
            if ((ALLOW_UNALIGNED == 0) && reqMisaligned) begin
              state_q     <= RESP;
              respValid_q <= 1'b1;
              misalign_q  <= 1'b1;
            end else begin
              state_q    <= BEAT;
              memEn_q    <= 1'b1;
              memAdr_q   <= beatAdr_d;
              weI_q      <= weI_d;
              weD_q      <= weD_d;
              memWdata_q <= wdata_d;
            end
          end
        end
        BEAT: begin
          if (!is_store(op_q)) begin
            state_q <= WAIT;
            cnt_q   <= WAIT_INIT;
          end else if (crossing && !beat_q) begin
            beat_q     <= 1'b1;
            memEn_q    <= 1'b1;
            memAdr_q   <= beatAdr_d;
            weI_q      <= weI_d;
            weD_q      <= weD_d;
            memWdata_q <= wdata_d;
          end else begin
            state_q     <= RESP;
            respValid_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else if (crossing && !beat_q) begin
            word0_q    <= readWord;
            beat_q     <= 1'b1;
            state_q    <= BEAT;
            memEn_q    <= 1'b1;
            memAdr_q   <= beatAdr_d;
            weI_q      <= weI_d;
            weD_q      <= weD_d;
            memWdata_q <= wdata_d;
          end else begin
            state_q     <= RESP;
            respValid_q <= 1'b1;
            respData_q  <= loadResult;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          reqReady_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = reqReady_q;
  assign mem_en     = memEn_q;
  assign mem_adr    = memAdr_q;
  assign we_i       = weI_q;
  assign we_d       = weD_q;
  assign mem_wdata  = memWdata_q;
  assign resp_valid = respValid_q;
  assign resp_data  = respData_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_ls_unit.sv
// tb_ls_unit
//   Directed bench for ls_unit. Two instances share clock and reset:
//   dutA (MEM_LATENCY=2, unaligned accesses split) and dutR (MEM_LATENCY=1,
//   unaligned accesses rejected). Each instance has a small block-RAM model
//   with the matching read latency.

module tb_ls_unit;
  import ls_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        reqValidA, reqReadyA, memEnA, respValidA, misalignA;
  logic [2:0]  reqOpA;
  logic [31:0] reqAddrA, reqWdataA, memWdataA, rdataIA, rdataDA, respDataA;
  logic [11:0] memAdrA;
  logic [3:0]  weIA, weDA;

  logic        reqValidR, reqReadyR, memEnR, respValidR, misalignR;
  logic [2:0]  reqOpR;
  logic [31:0] reqAddrR, reqWdataR, memWdataR, rdataIR, rdataDR, respDataR;
  logic [11:0] memAdrR;
  logic [3:0]  weIR, weDR;

  ls_unit #(.ADDR_W(12), .MEM_LATENCY(2), .ALLOW_UNALIGNED(1)) dutA (
    .clk(clk), .rst(rst),
    .req_valid(reqValidA), .req_ready(reqReadyA), .req_op(reqOpA),
    .req_addr(reqAddrA), .req_wdata(reqWdataA),
    .mem_en(memEnA), .mem_adr(memAdrA), .we_i(weIA), .we_d(weDA),
    .mem_wdata(memWdataA), .mem_rdata_i(rdataIA), .mem_rdata_d(rdataDA),
    .resp_valid(respValidA), .resp_data(respDataA), .misalign(misalignA)
  );

  ls_unit #(.ADDR_W(12), .MEM_LATENCY(1), .ALLOW_UNALIGNED(0)) dutR (
    .clk(clk), .rst(rst),
    .req_valid(reqValidR), .req_ready(reqReadyR), .req_op(reqOpR),
    .req_addr(reqAddrR), .req_wdata(reqWdataR),
    .mem_en(memEnR), .mem_adr(memAdrR), .we_i(weIR), .we_d(weDR),
    .mem_wdata(memWdataR), .mem_rdata_i(rdataIR), .mem_rdata_d(rdataDR),
    .resp_valid(respValidR), .resp_data(respDataR), .misalign(misalignR)
  );

  // Read-only memory contents shared by both RAM models.
  logic [31:0] imem [0:4095];
  logic [31:0] dmem [0:4095];

  // Two-stage read pipe for dutA, one stage for dutR: data appears
  // MEM_LATENCY edges after the edge that samples mem_en.
  logic [31:0] pipeIA0, pipeIA1, pipeDA0, pipeDA1, pipeIR0, pipeDR0;

  always @(posedge clk) begin
    if (memEnA) begin
      pipeIA0 <= imem[memAdrA];
      pipeDA0 <= dmem[memAdrA];
    end
    pipeIA1 <= pipeIA0;
    pipeDA1 <= pipeDA0;
    if (memEnR) begin
      pipeIR0 <= imem[memAdrR];
      pipeDR0 <= dmem[memAdrR];
    end
  end

  assign rdataIA = pipeIA1;
  assign rdataDA = pipeDA1;
  assign rdataIR = pipeIR0;
  assign rdataDR = pipeDR0;

  // Output view of whichever instance the current transaction targets.
  logic        useRej;
  logic        selReady, selMemEn, selRespValid, selMisalign;
  logic [11:0] selAdr;
  logic [3:0]  selWeI, selWeD;
  logic [31:0] selWdata, selRespData;

  always_comb begin
    selReady     = useRej ? reqReadyR  : reqReadyA;
    selMemEn     = useRej ? memEnR     : memEnA;
    selRespValid = useRej ? respValidR : respValidA;
    selMisalign  = useRej ? misalignR  : misalignA;
    selAdr       = useRej ? memAdrR    : memAdrA;
    selWeI       = useRej ? weIR       : weIA;
    selWeD       = useRej ? weDR       : weDA;
    selWdata     = useRej ? memWdataR  : memWdataA;
    selRespData  = useRej ? respDataR  : respDataA;
  end

  int checkCount = 0;
  int errorCount = 0;

  // Per-transaction trace; cycle index k = 1 is the sample just after the
  // accept edge.
  int          nBeats, respCount, respK;
  int          beatK [0:3];
  logic [11:0] beatAdr [0:3];
  logic [3:0]  beatWeI [0:3];
  logic [3:0]  beatWeD [0:3];
  logic [31:0] beatData [0:3];
  logic [31:0] respDataSeen;
  logic        respMisSeen, readyK1;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issues one request to the chosen instance and records the following
  // 12 cycles. req_valid stays high for holdK samples after acceptance to
  // show that requests during a busy period are not taken.
  task automatic applyStimulus(input bit rej, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int holdK);
    useRej = rej;
    @(negedge clk);
    checkOutput("ready_before_req", {31'b0, selReady}, 32'd1);
    if (rej) begin
      reqValidR = 1'b1; reqOpR = op; reqAddrR = addr; reqWdataR = wdata;
    end else begin
      reqValidA = 1'b1; reqOpA = op; reqAddrA = addr; reqWdataA = wdata;
    end
    @(posedge clk);
    #1;
    nBeats = 0; respCount = 0; respK = -1;
    respDataSeen = 32'h0; respMisSeen = 1'b0; readyK1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k > holdK) begin
        reqValidA = 1'b0;
        reqValidR = 1'b0;
      end
      if (k == 1) readyK1 = selReady;
      if (selMemEn) begin
        if (nBeats < 4) begin
          beatK[nBeats]    = k;
          beatAdr[nBeats]  = selAdr;
          beatWeI[nBeats]  = selWeI;
          beatWeD[nBeats]  = selWeD;
          beatData[nBeats] = selWdata;
        end
        nBeats++;
      end
      if (selRespValid) begin
        respCount++;
        if (respK < 0) begin
          respK        = k;
          respDataSeen = selRespData;
          respMisSeen  = selMisalign;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkTxn(input string tag, input int expBeats, input int expRespK,
                          input logic [31:0] expData, input logic expMis);
    checkOutput({tag, "_busy"}, {31'b0, readyK1}, 32'd0);
    checkOutput({tag, "_beats"}, 32'(nBeats), 32'(expBeats));
    checkOutput({tag, "_respcount"}, 32'(respCount), 32'd1);
    checkOutput({tag, "_respk"}, 32'(respK), 32'(expRespK));
    checkOutput({tag, "_data"}, respDataSeen, expData);
    checkOutput({tag, "_mis"}, {31'b0, respMisSeen}, {31'b0, expMis});
  endtask

  task automatic checkBeat(input string tag, input int i, input int k,
                           input logic [11:0] adr, input logic [3:0] wei,
                           input logic [3:0] wed);
    checkOutput({tag, "_k"}, 32'(beatK[i]), 32'(k));
    checkOutput({tag, "_adr"}, {20'h0, beatAdr[i]}, {20'h0, adr});
    checkOutput({tag, "_wei"}, {28'h0, beatWeI[i]}, {28'h0, wei});
    checkOutput({tag, "_wed"}, {28'h0, beatWeD[i]}, {28'h0, wed});
  endtask

  task automatic checkStoreData(input string tag, input int i, input logic [31:0] data);
    checkOutput({tag, "_wdata"}, beatData[i], data);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int evtCount;

    for (int i = 0; i < 4096; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
    dmem[1]      = 32'h12F0AB34;
    dmem[0]      = 32'h89ABCDEF;
    dmem[12'hFFF] = 32'h01234567;
    imem[1]      = 32'hCAFE0081;

    useRej    = 1'b0;
    reqValidA = 1'b0; reqOpA = 3'b000; reqAddrA = 32'h0; reqWdataA = 32'h0;
    reqValidR = 1'b0; reqOpR = 3'b000; reqAddrR = 32'h0; reqWdataR = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] checking reset state");
    checkOutput("rst_ready",    {31'b0, reqReadyA},  32'd1);
    checkOutput("rst_ready_r",  {31'b0, reqReadyR},  32'd1);
    checkOutput("rst_mem_en",   {31'b0, memEnA},     32'd0);
    checkOutput("rst_we",       {24'h0, weIA, weDA}, 32'd0);
    checkOutput("rst_resp",     {31'b0, respValidA}, 32'd0);
    checkOutput("rst_resp_data", respDataA,          32'd0);
    checkOutput("rst_misalign", {31'b0, misalignA},  32'd0);
    checkOutput("rst_adr",      {20'h0, memAdrA},    32'd0);
    checkOutput("rst_wdata",    memWdataA,           32'd0);
    rst = 1'b0;

    $display("[TB] SB to dmem offset 2");
    applyStimulus(1'b0, LS_SB, 32'h10000002, 32'h000000AB, 0);
    checkTxn("sb", 1, 2, 32'h0, 1'b0);
    checkBeat("sb_b0", 0, 1, 12'h000, 4'b0000, 4'b0010);
    checkStoreData("sb_b0", 0, 32'h0000AB00);

    $display("[TB] LH / LHU at odd offset");
    applyStimulus(1'b0, LS_LH, 32'h10000005, 32'h0, 0);
    checkTxn("lh", 1, 4, 32'hFFFFF0AB, 1'b0);
    checkBeat("lh_b0", 0, 1, 12'h001, 4'b0000, 4'b0000);
    applyStimulus(1'b0, LS_LHU, 32'h10000005, 32'h0, 0);
    checkTxn("lhu", 1, 4, 32'h0000F0AB, 1'b0);

    $display("[TB] split SW to both regions, req_valid held while busy");
    applyStimulus(1'b0, LS_SW, 32'h30000002, 32'hAABBCCDD, 2);
    checkTxn("sw", 2, 3, 32'h0, 1'b0);
    checkBeat("sw_b0", 0, 1, 12'h000, 4'b0011, 4'b0011);
    checkStoreData("sw_b0", 0, 32'h0000AABB);
    checkBeat("sw_b1", 1, 2, 12'h001, 4'b1100, 4'b1100);
    checkStoreData("sw_b1", 1, 32'hCCDD0000);

    $display("[TB] split LW wrapping the word address");
    applyStimulus(1'b0, LS_LW, 32'h10003FFE, 32'h0, 0);
    checkTxn("lw", 2, 7, 32'h456789AB, 1'b0);
    checkBeat("lw_b0", 0, 1, 12'hFFF, 4'b0000, 4'b0000);
    checkBeat("lw_b1", 1, 4, 12'h000, 4'b0000, 4'b0000);

    $display("[TB] LB from imem, LBU from unmapped region");
    applyStimulus(1'b0, LS_LB, 32'h20000007, 32'h0, 0);
    checkTxn("lb_imem", 1, 4, 32'hFFFFFF81, 1'b0);
    applyStimulus(1'b0, LS_LBU, 32'h00000004, 32'h0, 0);
    checkTxn("lbu_none", 1, 4, 32'h00000000, 1'b0);

    $display("[TB] split SH with addr[31] set, no enables");
    applyStimulus(1'b0, LS_SH, 32'hB0000003, 32'h00001234, 0);
    checkTxn("sh_hi", 2, 3, 32'h0, 1'b0);
    checkBeat("sh_hi_b0", 0, 1, 12'h000, 4'b0000, 4'b0000);
    checkStoreData("sh_hi_b0", 0, 32'h00000012);
    checkBeat("sh_hi_b1", 1, 2, 12'h001, 4'b0000, 4'b0000);
    checkStoreData("sh_hi_b1", 1, 32'h34000000);

    $display("[TB] rejecting instance");
    applyStimulus(1'b1, LS_SH, 32'h10000001, 32'h00001234, 0);
    checkTxn("rej_sh", 0, 1, 32'h0, 1'b1);
    applyStimulus(1'b1, LS_LH, 32'h10000006, 32'h0, 0);
    checkTxn("rej_lh_ok", 1, 3, 32'hFFFFAB34, 1'b0);
    checkBeat("rej_lh_b0", 0, 1, 12'h001, 4'b0000, 4'b0000);

    $display("[TB] reset between the beats of a split store");
    useRej = 1'b0;
    @(negedge clk);
    reqValidA = 1'b1; reqOpA = LS_SW; reqAddrA = 32'h10000001; reqWdataA = 32'h11223344;
    @(posedge clk);
    #1;
    reqValidA = 1'b0;
    checkOutput("mid_b0_en",    {31'b0, memEnA}, 32'd1);
    checkOutput("mid_b0_wed",   {28'h0, weDA},   32'h7);
    checkOutput("mid_b0_wdata", memWdataA,       32'h00112233);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_en", {31'b0, memEnA},     32'd0);
    checkOutput("mid_rst_we", {24'h0, weIA, weDA}, 32'd0);
    evtCount = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      if (memEnA || respValidA) evtCount++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (memEnA || respValidA) evtCount++;
    end
    checkOutput("mid_rst_no_events", 32'(evtCount), 32'd0);
    checkOutput("mid_rst_ready", {31'b0, reqReadyA}, 32'd1);

    $display("[TB] store to imem after reset");
    applyStimulus(1'b0, LS_SB, 32'h20000000, 32'h0000005A, 0);
    checkTxn("post_sb", 1, 2, 32'h0, 1'b0);
    checkBeat("post_sb_b0", 0, 1, 12'h000, 4'b1000, 4'b0000);
    checkStoreData("post_sb_b0", 0, 32'h5A000000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
